// File: rtl/fp_addsub_align_shift.sv
// Two-stage alignment shifter: coarse byte shift, then fine 0-7 bit shift.
// Ports: valid/ready in/out, Mmin/Mmax/CExp/Shift/Side in, MminS/Sticky/MmaxO/CExpO/SideO out.
module fp_addsub_align_shift #(
  parameter int SIDE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Mmin,
  input  logic [24:0]       Mmax,
  input  logic [7:0]        CExp,
  input  logic [4:0]        Shift,
  input  logic [SIDE_W-1:0] Side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       MminS,
  output logic              Sticky,
  output logic [24:0]       MmaxO,
  output logic [7:0]        CExpO,
  output logic [SIDE_W-1:0] SideO
);

  logic              s1_valid_q, s2_valid_q;
  logic              adv1, adv2;

  logic [31:0]       m1_d, m1_q;
  logic              st1_d, st1_q;
  logic [2:0]        fine_q;
  logic [24:0]       mmax1_q;
  logic [7:0]        cexp1_q;
  logic [SIDE_W-1:0] side1_q;

  logic [31:0]       m2_d, m2_q;
  logic              st2_d, st2_q;
  logic [31:0]       fmask;
  logic [24:0]       mmax2_q;
  logic [7:0]        cexp2_q;
  logic [SIDE_W-1:0] side2_q;

  assign adv2      = !s2_valid_q | out_ready;
  assign adv1      = !s1_valid_q | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid_q;

  // Coarse step: whole-byte shift, sticky collects the dropped bytes.
  always_comb begin
    m1_d  = Mmin;
    st1_d = 1'b0;
    unique case (Shift[4:3])
      2'd0: begin
        m1_d  = Mmin;
        st1_d = 1'b0;
      end
      2'd1: begin
        m1_d  = {8'b0, Mmin[31:8]};
        st1_d = |Mmin[7:0];
      end
      2'd2: begin
        m1_d  = {16'b0, Mmin[31:16]};
        st1_d = |Mmin[15:0];
      end
      2'd3: begin
        m1_d  = {24'b0, Mmin[31:24]};
        st1_d = |Mmin[23:0];
      end
    endcase
  end

  // Fine step: mask selects the low `fine` bits about to fall off.
  always_comb begin
    fmask = (32'd1 << fine_q) - 32'd1;
    m2_d  = m1_q >> fine_q;
    st2_d = st1_q | (|(m1_q & fmask));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      m1_q       <= '0;
      st1_q      <= 1'b0;
      fine_q     <= '0;
      mmax1_q    <= '0;
      cexp1_q    <= '0;
      side1_q    <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      m1_q       <= m1_d;
      st1_q      <= st1_d;
      fine_q     <= Shift[2:0];
      mmax1_q    <= Mmax;
      cexp1_q    <= CExp;
      side1_q    <= Side;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      m2_q       <= '0;
      st2_q      <= 1'b0;
      mmax2_q    <= '0;
      cexp2_q    <= '0;
      side2_q    <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      m2_q       <= m2_d;
      st2_q      <= st2_d;
      mmax2_q    <= mmax1_q;
      cexp2_q    <= cexp1_q;
      side2_q    <= side1_q;
    end
  end

  assign MminS  = m2_q;
  assign Sticky = st2_q;
  assign MmaxO  = mmax2_q;
  assign CExpO  = cexp2_q;
  assign SideO  = side2_q;

endmodule

// File: tb/tb_fp_addsub_align_shift.sv
// Bench for fp_addsub_align_shift: scoreboard model, directed
// vectors, backpressure, mid-flight reset and random traffic.
module tb_fp_addsub_align_shift;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   Mmin = '0;
  logic [24:0]   Mmax = '0;
  logic [7:0]    CExp = '0;
  logic [4:0]    Shift = '0;
  logic [SW-1:0] Side = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   MminS;
  logic          Sticky;
  logic [24:0]   MmaxO;
  logic [7:0]    CExpO;
  logic [SW-1:0] SideO;

  fp_addsub_align_shift #(.SIDE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Mmin(Mmin), .Mmax(Mmax), .CExp(CExp),
    .Shift(Shift), .Side(Side),
    .out_valid(out_valid), .out_ready(out_ready),
    .MminS(MminS), .Sticky(Sticky), .MmaxO(MmaxO),
    .CExpO(CExpO), .SideO(SideO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   m;
    logic          st;
    logic [24:0]   mx;
    logic [7:0]    ce;
    logic [SW-1:0] sd;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic exp_t model(input logic [31:0] mm, input logic [4:0] sh,
                                 input logic [24:0] mx, input logic [7:0] ce,
                                 input logic [SW-1:0] sd);
    exp_t e;
    logic [63:0] w;
    w    = {mm, 32'b0} >> sh;
    e.m  = w[63:32];
    e.st = |w[31:0];
    e.mx = mx;
    e.ce = ce;
    e.sd = sd;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sample 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_MminS", 64'(MminS), 64'd0);
      chk("rst_Sticky", 64'(Sticky), 64'd0);
      chk("rst_MmaxO", 64'(MmaxO), 64'd0);
      chk("rst_CExpO", 64'(CExpO), 64'd0);
      chk("rst_SideO", 64'(SideO), 64'd0);
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          chk("MminS", 64'(MminS), 64'(q[0].m));
          chk("Sticky", 64'(Sticky), 64'(q[0].st));
          chk("MmaxO", 64'(MmaxO), 64'(q[0].mx));
          chk("CExpO", 64'(CExpO), 64'(q[0].ce));
          chk("SideO", 64'(SideO), 64'(q[0].sd));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(Mmin, Shift, Mmax, CExp, Side));
    end
  end

  task automatic dir(input logic [31:0] mm, input logic [4:0] sh, input logic [7:0] ce,
                     input logic [31:0] em, input logic es);
    int lat;
    bit got;
    @(negedge clk);
    Mmin = mm; Shift = sh; CExp = ce;
    Mmax = 25'($urandom); Side = SW'($urandom);
    in_valid = 1'b1; out_ready = 1'b1;
    #4;
    chk("dir_accept", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    got = 0;
    lat = 1;
    while (!got && lat <= 6) begin
      #4;
      if (out_valid) begin
        got = 1;
        chk("dir_latency", 64'(lat), 64'd2);
        chk("dir_MminS", 64'(MminS), 64'(em));
        chk("dir_Sticky", 64'(Sticky), 64'(es));
        chk("dir_CExpO", 64'(CExpO), 64'(ce));
      end else begin
        lat++;
        @(negedge clk);
      end
    end
    if (!got) chk("dir_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    #4;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic stream(input bit bp);
    int idx, cyc, acc;
    idx = 0; cyc = 0; acc = 0;
    while (idx < 8 && cyc < 50) begin
      @(negedge clk);
      in_valid = 1'b1;
      Mmin = $urandom;
      Mmax = 25'($urandom);
      Side = SW'($urandom);
      Shift = 5'(idx);
      CExp = 8'h10 + 8'(idx);
      out_ready = (cyc >= 3) || !bp;
      #4;
      if (in_ready) begin
        if (bp && cyc < 3) acc++;
        idx++;
      end
      cyc++;
    end
    chk("stream_all_sent", 64'(idx), 64'd8);
    if (bp) chk("bp_accepts", 64'(acc), 64'd2);
    drain();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #2;
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_MminS", 64'(MminS), 64'd0);
    chk("idle_CExpO", 64'(CExpO), 64'd0);

    dir(32'h8000_0000, 5'd0, 8'h7F, 32'h8000_0000, 1'b0);
    dir(32'hFFFF_FF80, 5'd7, 8'h11, 32'h01FF_FFFF, 1'b0);
    dir(32'hFFFF_FF80, 5'd9, 8'h12, 32'h007F_FFFF, 1'b1);
    dir(32'h8000_0000, 5'd31, 8'h13, 32'h0000_0001, 1'b0);
    dir(32'hC000_0000, 5'd31, 8'h14, 32'h0000_0001, 1'b1);
    dir(32'h0000_00FF, 5'd8, 8'h15, 32'h0000_0000, 1'b1);
    dir(32'h1234_5678, 5'd20, 8'h16, 32'h0000_0123, 1'b1);

    stream(1'b0);
    stream(1'b1);

    // Two beats parked in the pipe, then asynchronous reset.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    Mmin = 32'hDEAD_BEEF; Shift = 5'd3;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_MminS", 64'(MminS), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    #4;
    chk("no_stale_out", 64'(out_valid), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      Mmin = $urandom;
      Mmax = 25'($urandom);
      CExp = 8'($urandom);
      Shift = 5'($urandom);
      Side = SW'($urandom);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
